// File: rtl/button_debounce_if.sv
// Signal bundle between raw pad conditioning and the SoC-facing button port.
// Optional interrupt signals appear only when BUTTON_IRQ_EN is defined.
interface button_debounce_if #(
  parameter int unsigned BUTTONCOUNT = 4
);
  logic [BUTTONCOUNT-1:0] buttons_in;
  logic [BUTTONCOUNT-1:0] buttons_out;
  logic [BUTTONCOUNT-1:0] pressed;
  logic [BUTTONCOUNT-1:0] released;
`ifdef BUTTON_IRQ_EN
  logic [BUTTONCOUNT-1:0] event_clear;
  logic                   irq;

  modport master (
    output buttons_in, event_clear,
    input  buttons_out, pressed, released, irq
  );

  modport slave (
    input  buttons_in, event_clear,
    output buttons_out, pressed, released, irq
  );
`else
  modport master (
    output buttons_in,
    input  buttons_out, pressed, released
  );

  modport slave (
    input  buttons_in,
    output buttons_out, pressed, released
  );
`endif
endinterface

// File: rtl/button_debounce.sv
// Per-button synchronizer, polarity fix, counter debounce and press/release pulses.
// Define BUTTON_IRQ_EN to add sticky press events with a registered interrupt.
module button_debounce #(
  parameter int unsigned BUTTONCOUNT     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input logic              clk,
  input logic              reset,
  button_debounce_if.slave bus
);

  localparam int unsigned            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BUTTONCOUNT-1:0] IDLE     = ACTIVE_LOW ? '1 : '0;

  logic [BUTTONCOUNT-1:0] sync0;
  logic [BUTTONCOUNT-1:0] sync1;
  logic [BUTTONCOUNT-1:0] level;
  logic [BUTTONCOUNT-1:0] out_q;
  logic [BUTTONCOUNT-1:0] pressed_q;
  logic [BUTTONCOUNT-1:0] released_q;
  logic [CW-1:0]          cnt [BUTTONCOUNT];

  // Sync flops idle at the unpressed pad level, so level reads 0 out of reset.
  assign level = sync1 ^ IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0      <= IDLE;
      sync1      <= IDLE;
      out_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int unsigned i = 0; i < BUTTONCOUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync0      <= bus.buttons_in;
      sync1      <= sync0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int unsigned i = 0; i < BUTTONCOUNT; i++) begin
        if (level[i] == out_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          out_q[i]      <= level[i];
          cnt[i]        <= '0;
          pressed_q[i]  <= level[i];
          released_q[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign bus.buttons_out = out_q;
  assign bus.pressed     = pressed_q;
  assign bus.released    = released_q;

`ifdef BUTTON_IRQ_EN
  logic [BUTTONCOUNT-1:0] event_flags;
  logic                   irq_q;

  // A press landing in the same cycle as its clear keeps the event set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_flags <= '0;
      irq_q       <= 1'b0;
    end else begin
      event_flags <= pressed_q | (event_flags & ~bus.event_clear);
      irq_q       <= |event_flags;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: expected outputs are queued per clock and
// checked at the falling edge; define BUTTON_IRQ_EN to also exercise the interrupt.
module tb_button_debounce;

  localparam int unsigned N   = 4;
  localparam int unsigned DC  = 8;
  localparam int          LAT = DC + 2;  // ticks from drive point to visible output

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_debounce_if #(.BUTTONCOUNT(N)) bus ();

  button_debounce #(
    .BUTTONCOUNT    (N),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic [3:0] bo;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  string phase     = "reset";

  logic [3:0] exp_bo  = '0;
  logic       exp_irq = 1'b0;
  logic [3:0] chg_mask [int];
  logic [3:0] chg_val  [int];
  logic       irq_at   [int];

  task automatic sched_bo(input int c, input logic [3:0] m, input logic [3:0] v);
    if (chg_mask.exists(c)) begin
      chg_mask[c] = chg_mask[c] | m;
      chg_val[c]  = (chg_val[c] & ~m) | (v & m);
    end else begin
      chg_mask[c] = m;
      chg_val[c]  = v & m;
    end
    if (|(m & v)) irq_at[c + 2] = 1'b1;
  endtask

  task automatic tick();
    exp_t e;
    logic [3:0] m;
    logic [3:0] v;
    @(posedge clk);
    cyc++;
    #1;
    e.tag = phase;
    e.cyc = cyc;
    e.pr  = '0;
    e.rl  = '0;
    if (reset) begin
      exp_bo  = '0;
      exp_irq = 1'b0;
    end else begin
      if (chg_mask.exists(cyc)) begin
        m      = chg_mask[cyc];
        v      = chg_val[cyc];
        e.pr   = m & v & ~exp_bo;
        e.rl   = m & ~v & exp_bo;
        exp_bo = (exp_bo & ~m) | v;
        chg_mask.delete(cyc);
        chg_val.delete(cyc);
      end
      if (irq_at.exists(cyc)) begin
        exp_irq = irq_at[cyc];
        irq_at.delete(cyc);
      end
    end
    e.bo  = exp_bo;
    e.irq = exp_irq;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      assert (bus.buttons_out === e.bo) else begin
        mismatched++;
        $error("FAIL %s cyc%0d buttons_out got %b want %b", e.tag, e.cyc, bus.buttons_out, e.bo);
      end
      compared++;
      assert (bus.pressed === e.pr) else begin
        mismatched++;
        $error("FAIL %s cyc%0d pressed got %b want %b", e.tag, e.cyc, bus.pressed, e.pr);
      end
      compared++;
      assert (bus.released === e.rl) else begin
        mismatched++;
        $error("FAIL %s cyc%0d released got %b want %b", e.tag, e.cyc, bus.released, e.rl);
      end
`ifdef BUTTON_IRQ_EN
      compared++;
      assert (bus.irq === e.irq) else begin
        mismatched++;
        $error("FAIL %s cyc%0d irq got %b want %b", e.tag, e.cyc, bus.irq, e.irq);
      end
`endif
    end
  end

  initial begin
    reset          = 1'b1;
    bus.buttons_in = 4'b1111;
`ifdef BUTTON_IRQ_EN
    bus.event_clear = '0;
`endif

    // Outputs stay 0 under reset, then the held pads are accepted together.
    ticks(3);
    reset = 1'b0;
    phase = "reset_release";
    sched_bo(cyc + LAT, 4'b1111, 4'b1111);
    ticks(12);

    phase = "all_release";
    bus.buttons_in = 4'b0000;
    sched_bo(cyc + LAT, 4'b1111, 4'b0000);
    ticks(12);

    phase = "clean_press";
    bus.buttons_in = 4'b0001;
    sched_bo(cyc + LAT, 4'b0001, 4'b0001);
    ticks(12);

    // Bounces of 1, 3 and 7 cycles must be rejected.
    phase = "bounce";
    bus.buttons_in[1] = 1'b1; ticks(1);
    bus.buttons_in[1] = 1'b0; ticks(2);
    bus.buttons_in[1] = 1'b1; ticks(3);
    bus.buttons_in[1] = 1'b0; ticks(2);
    bus.buttons_in[1] = 1'b1; ticks(7);
    bus.buttons_in[1] = 1'b0; ticks(2);
    phase = "bounce_hold";
    bus.buttons_in[1] = 1'b1;
    sched_bo(cyc + LAT, 4'b0010, 4'b0010);
    ticks(12);

    phase = "press_23";
    bus.buttons_in = 4'b1110;
    sched_bo(cyc + LAT, 4'b1101, 4'b1100);
    ticks(12);

    phase = "simultaneous";
    bus.buttons_in = 4'b1011;
    sched_bo(cyc + LAT, 4'b0101, 4'b0001);
    ticks(12);

    phase = "drop_all";
    bus.buttons_in = 4'b0000;
    sched_bo(cyc + LAT, 4'b1111, 4'b0000);
    ticks(12);

    // Reset while channel 1 has counted to 5.
    phase = "mid_count";
    bus.buttons_in = 4'b0010;
    ticks(7);
    reset = 1'b1;
    chg_mask.delete();
    chg_val.delete();
    irq_at.delete();
    phase = "mid_reset";
    ticks(3);
    reset = 1'b0;
    phase = "re_press";
    sched_bo(cyc + LAT, 4'b0010, 4'b0010);
    ticks(12);

`ifdef BUTTON_IRQ_EN
    phase = "irq_prep";
    bus.buttons_in = 4'b0000;
    sched_bo(cyc + LAT, 4'b0010, 4'b0000);
    ticks(12);
    bus.event_clear = 4'b1111;
    irq_at[cyc + 2] = 1'b0;
    ticks(1);
    bus.event_clear = '0;
    ticks(4);

    phase = "irq_press";
    bus.buttons_in = 4'b0001;
    sched_bo(cyc + LAT, 4'b0001, 4'b0001);
    ticks(13);
    bus.buttons_in = 4'b0000;
    sched_bo(cyc + LAT, 4'b0001, 4'b0000);
    ticks(12);

    phase = "irq_clear";
    bus.event_clear = 4'b0001;
    irq_at[cyc + 2] = 1'b0;
    ticks(1);
    bus.event_clear = '0;
    ticks(4);

    // Clear coincides with the cycle pressed[0] is high: event must survive.
    phase = "irq_set_wins";
    bus.buttons_in = 4'b0001;
    sched_bo(cyc + LAT, 4'b0001, 4'b0001);
    ticks(LAT);
    bus.event_clear = 4'b0001;
    ticks(1);
    bus.event_clear = '0;
    ticks(4);

    phase = "irq_final_clear";
    bus.event_clear = 4'b0001;
    irq_at[cyc + 2] = 1'b0;
    ticks(1);
    bus.event_clear = '0;
    ticks(4);
`endif

    @(negedge clk);
    #1;
    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
